// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmitter slice.
//   uart_tx_state_e : transmitter FSM states
//   parity_mode_e   : run-time parity selection (code 3 behaves as none)
//   div_calc        : clocks per baud tick for a given clock/baud/oversampling
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_mode_e;

   function automatic int div_calc(input int clk_hz, input int baud, input int ovs);
      return clk_hz / (baud * ovs);
   endfunction

endpackage

// File: rtl/uart_tx_frame_baud_gen.sv
// uart_baud_gen: restartable baud tick divider.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   en   : count enable; while low the divider is held at 0 so every
//          frame starts from a fresh phase
//   tick : one-clock pulse every DIV clocks while enabled
module uart_baud_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   import uart_pkg::*;

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_r;

   assign tick = en && (cnt_r == CW'(DIV - 1));

   // divider count: wraps after DIV-1, cleared whenever disabled
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r <= '0;
      end else if (!en || tick) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input.
//   clk, rst    : system clock, synchronous active-low reset
//   in_data     : payload, bit 0 sent first
//   in_valid    : payload offered; in_ready: payload accepted when both high
//   parity_mode : 0/3 none, 1 even, 2 odd; latched at accept
//   tx          : registered serial line, idles high
//   tx_busy     : frame (or break sequence) in progress, equals !in_ready
//   tx_done     : one-clock pulse as the last stop bit ends
// Optional macro UART_TX_BREAK_EN adds input break_req: while held in IDLE
// the line is forced low, then held high for one bit time before in_ready.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD        = 9600,
   parameter int OVS         = 16,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           parity_mode,
`ifdef UART_TX_BREAK_EN
   input  logic                 break_req,
`endif
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int DIV = div_calc(CLK_FREQ_HZ, BAUD, OVS);
   localparam int BCW = $clog2(DATA_BITS);
   localparam int TCW = $clog2(OVS);

   if (DIV < 1) begin : g_div_check
      $error("uart_tx_frame: CLK_FREQ_HZ/(BAUD*OVS) must be at least 1");
   end

   uart_tx_state_e       state_r, state_s;
   logic [DATA_BITS-1:0] shift_r, shift_s;
   logic [BCW-1:0]       bit_cnt_r, bit_cnt_s;
   logic [TCW-1:0]       tick_cnt_r, tick_cnt_s, tick_adv_s;
   logic                 stop_cnt_r, stop_cnt_s;
   logic                 par_en_r, par_en_s;
   logic                 par_bit_r, par_bit_s;
   logic                 tx_r, tx_s;
   logic                 in_ready_r, in_ready_s;
   logic                 tx_done_r, tx_done_s;
   logic                 tick_s, bit_end_s, accept_s, baud_en_s;
`ifdef UART_TX_BREAK_EN
   logic                 brk_on_r, brk_on_s;
   logic                 brk_rec_r, brk_rec_s;
`endif

   assign accept_s  = in_valid && in_ready_r;
   assign bit_end_s = tick_s && (tick_cnt_r == TCW'(OVS - 1));
`ifdef UART_TX_BREAK_EN
   assign baud_en_s = (state_r != IDLE) || brk_rec_r;
`else
   assign baud_en_s = (state_r != IDLE);
`endif

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (baud_en_s),
      .tick (tick_s)
   );

   // next-state and datapath update for the frame sequencer
   always_comb begin
      state_s    = state_r;
      shift_s    = shift_r;
      bit_cnt_s  = bit_cnt_r;
      stop_cnt_s = stop_cnt_r;
      par_en_s   = par_en_r;
      par_bit_s  = par_bit_r;
      tx_done_s  = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_on_s   = brk_on_r;
      brk_rec_s  = brk_rec_r;
`endif
      if (bit_end_s) begin
         tick_adv_s = '0;
      end else if (tick_s) begin
         tick_adv_s = tick_cnt_r + TCW'(1);
      end else begin
         tick_adv_s = tick_cnt_r;
      end
      tick_cnt_s = tick_adv_s;

      case (state_r)
         IDLE: begin
            tick_cnt_s = '0;
            if (accept_s) begin
               state_s    = START;
               shift_s    = in_data;
               bit_cnt_s  = '0;
               stop_cnt_s = 1'b0;
               par_en_s   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
               par_bit_s  = (parity_mode == PAR_ODD) ? ~(^in_data) : (^in_data);
            end
`ifdef UART_TX_BREAK_EN
            else if (break_req) begin
               brk_on_s  = 1'b1;
               brk_rec_s = 1'b0;
            end else if (brk_on_r) begin
               // break released: start the one-bit high recovery period
               brk_on_s  = 1'b0;
               brk_rec_s = 1'b1;
            end else if (brk_rec_r) begin
               tick_cnt_s = tick_adv_s;
               brk_rec_s  = !bit_end_s;
            end
`endif
            else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_s   = DATA;
               bit_cnt_s = '0;
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               shift_s = shift_r >> 1;
               if (bit_cnt_r == BCW'(DATA_BITS - 1)) begin
                  state_s    = par_en_r ? PARITY : STOP;
                  stop_cnt_s = 1'b0;
               end else begin
                  bit_cnt_s = bit_cnt_r + BCW'(1);
               end
            end else begin
               state_s = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               state_s    = STOP;
               stop_cnt_s = 1'b0;
            end else begin
               state_s = PARITY;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               if (stop_cnt_r == 1'(STOP_BITS - 1)) begin
                  state_s   = IDLE;
                  tx_done_s = 1'b1;
               end else begin
                  stop_cnt_s = 1'b1;
               end
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // line level and ready derived from the upcoming state so both are registered
   always_comb begin
      tx_s       = 1'b1;
      in_ready_s = 1'b0;
      case (state_s)
         IDLE: begin
`ifdef UART_TX_BREAK_EN
            tx_s       = !brk_on_s;
            in_ready_s = !brk_on_s && !brk_rec_s;
`else
            tx_s       = 1'b1;
            in_ready_s = 1'b1;
`endif
         end
         START:   tx_s = 1'b0;
         DATA:    tx_s = shift_s[0];
         PARITY:  tx_s = par_bit_s;
         STOP:    tx_s = 1'b1;
         default: tx_s = 1'b1;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= IDLE;
         shift_r    <= '0;
         bit_cnt_r  <= '0;
         tick_cnt_r <= '0;
         stop_cnt_r <= 1'b0;
         par_en_r   <= 1'b0;
         par_bit_r  <= 1'b0;
         tx_r       <= 1'b1;
         in_ready_r <= 1'b1;
         tx_done_r  <= 1'b0;
`ifdef UART_TX_BREAK_EN
         brk_on_r   <= 1'b0;
         brk_rec_r  <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         shift_r    <= shift_s;
         bit_cnt_r  <= bit_cnt_s;
         tick_cnt_r <= tick_cnt_s;
         stop_cnt_r <= stop_cnt_s;
         par_en_r   <= par_en_s;
         par_bit_r  <= par_bit_s;
         tx_r       <= tx_s;
         in_ready_r <= in_ready_s;
         tx_done_r  <= tx_done_s;
`ifdef UART_TX_BREAK_EN
         brk_on_r   <= brk_on_s;
         brk_rec_r  <= brk_rec_s;
`endif
      end
   end

   assign tx       = tx_r;
   assign in_ready = in_ready_r;
   assign tx_busy  = !in_ready_r;
   assign tx_done  = tx_done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame at 16 clocks per bit.
//   dut_a : 8 data bits, 1 stop bit
//   dut_b : 5 data bits, 2 stop bits
// Define UART_TX_BREAK_EN to also exercise the break sequence.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   int         total = 0;
   int         bad = 0;

   logic [7:0] a_in_data = 8'h00;
   logic       a_in_valid = 1'b0;
   logic [1:0] a_parity_mode = 2'd0;
   logic       a_in_ready, a_tx, a_tx_busy, a_tx_done;
   logic [4:0] b_in_data = 5'h00;
   logic       b_in_valid = 1'b0;
   logic [1:0] b_parity_mode = 2'd0;
   logic       b_in_ready, b_tx, b_tx_busy, b_tx_done;
`ifdef UART_TX_BREAK_EN
   logic       a_break_req = 1'b0;
   logic       b_break_req = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_tx_frame #(.CLK_FREQ_HZ(1600), .BAUD(100), .OVS(16), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .parity_mode(a_parity_mode),
`ifdef UART_TX_BREAK_EN
      .break_req(a_break_req),
`endif
      .tx(a_tx), .tx_busy(a_tx_busy), .tx_done(a_tx_done));

   uart_tx_frame #(.CLK_FREQ_HZ(1600), .BAUD(100), .OVS(16), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .parity_mode(b_parity_mode),
`ifdef UART_TX_BREAK_EN
      .break_req(b_break_req),
`endif
      .tx(b_tx), .tx_busy(b_tx_busy), .tx_done(b_tx_done));

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({a_tx, a_in_ready, a_tx_busy, a_tx_done} !== 4'b1100) begin
         bad++;
         $display("FAIL reset_a: tx/ready/busy/done=%b want 1100", {a_tx, a_in_ready, a_tx_busy, a_tx_done});
      end
      total++;
      if ({b_tx, b_in_ready, b_tx_busy, b_tx_done} !== 4'b1100) begin
         bad++;
         $display("FAIL reset_b: tx/ready/busy/done=%b want 1100", {b_tx, b_in_ready, b_tx_busy, b_tx_done});
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   // exp_bits[i] is the line level of the i-th bit period, start bit first
   task automatic test_frame_a(input string name, input logic [7:0] data, input logic [1:0] mode,
                               input logic [10:0] exp_bits, input int nbits);
      logic exp_tx;
      @(negedge clk);
      total++;
      if (a_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_ready: in_ready=%b want 1", name, a_in_ready);
      end
      a_in_data = data;
      a_parity_mode = mode;
      a_in_valid = 1'b1;
      @(negedge clk);
      // changing inputs mid-frame must not disturb the frame
      a_in_valid = 1'b0;
      a_in_data = ~data;
      a_parity_mode = 2'd0;
      for (int k = 0; k < nbits * 16; k++) begin
         exp_tx = exp_bits[k / 16];
         total++;
         if (a_tx !== exp_tx || a_tx_done !== 1'b0 || a_tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s clk %0d: tx=%b done=%b busy=%b want tx=%b done=0 busy=1",
                     name, k, a_tx, a_tx_done, a_tx_busy, exp_tx);
         end
         @(negedge clk);
      end
      total++;
      if ({a_tx, a_tx_done, a_in_ready, a_tx_busy} !== 4'b1110) begin
         bad++;
         $display("FAIL %s_end: tx/done/ready/busy=%b want 1110", name, {a_tx, a_tx_done, a_in_ready, a_tx_busy});
      end
      @(negedge clk);
      total++;
      if (a_tx_done !== 1'b0) begin
         bad++;
         $display("FAIL %s_done_width: tx_done=%b want 0", name, a_tx_done);
      end
   endtask

   task automatic test_frame_b(input string name, input logic [4:0] data, input logic [7:0] exp_bits);
      logic exp_tx;
      @(negedge clk);
      b_in_data = data;
      b_parity_mode = 2'd0;
      b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      for (int k = 0; k < 128; k++) begin
         exp_tx = exp_bits[k / 16];
         total++;
         if (b_tx !== exp_tx || b_tx_done !== 1'b0 || b_tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s clk %0d: tx=%b done=%b busy=%b want tx=%b done=0 busy=1",
                     name, k, b_tx, b_tx_done, b_tx_busy, exp_tx);
         end
         @(negedge clk);
      end
      total++;
      if ({b_tx, b_tx_done, b_in_ready} !== 3'b111) begin
         bad++;
         $display("FAIL %s_end: tx/done/ready=%b want 111", name, {b_tx, b_tx_done, b_in_ready});
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] f1;
      logic [9:0] f2;
      logic exp_tx, exp_done, exp_busy;
      int done_cnt;
      f1 = 10'b1010101010;   // stop, 8'h55 msb..lsb, start
      f2 = 10'b1101010100;   // stop, 8'hAA msb..lsb, start
      done_cnt = 0;
      @(negedge clk);
      a_in_data = 8'h55;
      a_parity_mode = 2'd0;
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_data = 8'hAA;
      for (int c = 0; c < 340; c++) begin
         if (c < 160) begin
            exp_tx = f1[c / 16]; exp_done = 1'b0; exp_busy = 1'b1;
         end else if (c == 160) begin
            exp_tx = 1'b1; exp_done = 1'b1; exp_busy = 1'b0;
         end else if (c < 321) begin
            exp_tx = f2[(c - 161) / 16]; exp_done = 1'b0; exp_busy = 1'b1;
         end else if (c == 321) begin
            exp_tx = 1'b1; exp_done = 1'b1; exp_busy = 1'b0;
         end else begin
            exp_tx = 1'b1; exp_done = 1'b0; exp_busy = 1'b0;
         end
         if (a_tx_done === 1'b1) done_cnt++;
         total++;
         if (a_tx !== exp_tx || a_tx_done !== exp_done || a_tx_busy !== exp_busy || a_in_ready !== !exp_busy) begin
            bad++;
            $display("FAIL b2b clk %0d: tx=%b done=%b busy=%b ready=%b want tx=%b done=%b busy=%b",
                     c, a_tx, a_tx_done, a_tx_busy, a_in_ready, exp_tx, exp_done, exp_busy);
         end
         if (c == 161) a_in_valid = 1'b0;
         @(negedge clk);
      end
      total++;
      if (done_cnt !== 2) begin
         bad++;
         $display("FAIL b2b_count: frames=%0d want 2", done_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      a_in_data = 8'h00;
      a_parity_mode = 2'd0;
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      repeat (49) @(negedge clk);
      total++;
      if (a_tx !== 1'b0 || a_tx_busy !== 1'b1) begin
         bad++;
         $display("FAIL midrst_pre: tx=%b busy=%b want tx=0 busy=1", a_tx, a_tx_busy);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({a_tx, a_tx_busy, a_in_ready, a_tx_done} !== 4'b1010) begin
         bad++;
         $display("FAIL midrst_edge: tx/busy/ready/done=%b want 1010", {a_tx, a_tx_busy, a_in_ready, a_tx_done});
      end
      rst = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         total++;
         if (a_tx_done !== 1'b0 || a_tx !== 1'b1) begin
            bad++;
            $display("FAIL midrst_quiet clk %0d: tx=%b done=%b want tx=1 done=0", k, a_tx, a_tx_done);
         end
      end
      test_frame_a("after_rst", 8'hA5, 2'd0, 11'b00_1101001010, 10);
   endtask

`ifdef UART_TX_BREAK_EN
   task automatic test_break();
      @(negedge clk);
      a_break_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         total++;
         if (a_tx !== 1'b0 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL break_hold clk %0d: tx=%b ready=%b want tx=0 ready=0", i, a_tx, a_in_ready);
         end
      end
      a_break_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         total++;
         if (a_tx !== 1'b1 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL break_recover clk %0d: tx=%b ready=%b want tx=1 ready=0", i, a_tx, a_in_ready);
         end
      end
      @(negedge clk);
      total++;
      if (a_tx !== 1'b1 || a_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL break_release: tx=%b ready=%b want tx=1 ready=1", a_tx, a_in_ready);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_frame_a("8n1_a5", 8'hA5, 2'd0, 11'b00_1101001010, 10);
      test_frame_a("8e1_07", 8'h07, 2'd1, 11'b11000001110, 11);
      test_frame_a("8o1_07", 8'h07, 2'd2, 11'b10000001110, 11);
      test_frame_a("mode3_07", 8'h07, 2'd3, 11'b00_1000001110, 10);
      test_frame_b("5n2_1f", 5'h1F, 8'b11111110);
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
      test_break();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
